// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_gate_ctrl
// Description : Idle-driven clock-gating controller. Watches request and
//               activity signals, counts idle cycles and drops the ICG enable
//               once the idle threshold is reached. On a new request it
//               re-enables the clock and waits WAKE_CYC cycles before
//               acknowledging that the gated clock is stable.
//
// Ports
//   clk        in   free-running ungated clock
//   rst_n      in   asynchronous active-low reset
//   req        in   client requests the gated clock
//   busy       in   gated-domain activity (meaningful only while clock runs)
//   force_on   in   keep the clock enabled regardless of idle state
//   idle_thr   in   idle cycles tolerated before gating (IDLE_W bits)
//   stat_clr   in   synchronous clear of the gated-cycle statistic
//   gate_en    out  registered enable for the downstream ICG E pin
//   ack        out  gated clock stable and usable
//   state_o    out  current state: RUN=0, COUNT=1, OFF=2, WAKE=3
//   gated_cyc  out  number of cycles spent in OFF
//
// Build option
//   CLK_GATE_STAT_EN : when defined, gated_cyc is a saturating 32-bit
//                      counter; when undefined, gated_cyc is tied to 0 and
//                      stat_clr is ignored.
//
// Revision    : 1.0  initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 4     // legal range 1..255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              busy,
    input  logic              force_on,
    input  logic [IDLE_W-1:0] idle_thr,
    input  logic              stat_clr,
    output logic              gate_en,
    output logic              ack,
    output logic [1:0]        state_o,
    output logic [31:0]       gated_cyc
);

    // Shared idle / wake counter; at least 8 bits so any legal WAKE_CYC fits.
    localparam int CNT_W = (IDLE_W > 8) ? IDLE_W : 8;
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        OFF   = 2'd2,
        WAKE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             activity;
    logic             wake_trigger;
    logic [CNT_W-1:0] thr_ext;

    // busy is not part of the wake trigger: with the clock stopped it is stale.
    assign activity     = req | busy | force_on;
    assign wake_trigger = req | force_on;
    assign thr_ext      = CNT_W'(idle_thr);

    // gate_en and ack are written alongside every state change so they are
    // plain flops with no input-to-output combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAKE;
            cnt     <= '0;
            gate_en <= 1'b1;
            ack     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!activity) begin
                        state <= COUNT;
                        cnt   <= '0;
                    end
                end
                COUNT: begin
                    // Activity is checked first so it wins over a threshold
                    // hit in the same cycle.
                    if (activity) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt >= thr_ext) begin
                        state   <= OFF;
                        gate_en <= 1'b0;
                        ack     <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OFF: begin
                    if (wake_trigger) begin
                        state   <= WAKE;
                        cnt     <= '0;
                        gate_en <= 1'b1;
                    end
                end
                WAKE: begin
                    // Not abortable: always runs to completion.
                    if (cnt == WAKE_LAST) begin
                        state <= RUN;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= WAKE;
                    cnt     <= '0;
                    gate_en <= 1'b1;
                    ack     <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

`ifdef CLK_GATE_STAT_EN
    logic [31:0] gated_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_cnt <= '0;
        end else if (stat_clr) begin
            gated_cnt <= '0;
        end else if ((state == OFF) && (gated_cnt != 32'hFFFF_FFFF)) begin
            gated_cnt <= gated_cnt + 32'd1;
        end
    end

    assign gated_cyc = gated_cnt;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign gated_cyc       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_gate_ctrl
// Description : Self-checking bench for clk_gate_ctrl. Directed scenarios
//               with hand-derived expectations, followed by randomized
//               stimulus compared against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_clk_gate_ctrl;

    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 4;
    localparam int CNT_MAX  = 255;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              req      = 1'b0;
    logic              busy     = 1'b0;
    logic              force_on = 1'b0;
    logic              stat_clr = 1'b0;
    logic [IDLE_W-1:0] idle_thr = 8'd3;
    logic              gate_en;
    logic              ack;
    logic [1:0]        state_o;
    logic [31:0]       gated_cyc;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=RUN 1=COUNT 2=OFF 3=WAKE
    int     m_mode;
    int     m_cnt;
    longint m_gc;

    clk_gate_ctrl #(
        .IDLE_W   (IDLE_W),
        .WAKE_CYC (WAKE_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .busy      (busy),
        .force_on  (force_on),
        .idle_thr  (idle_thr),
        .stat_clr  (stat_clr),
        .gate_en   (gate_en),
        .ack       (ack),
        .state_o   (state_o),
        .gated_cyc (gated_cyc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_edge(input logic r, input logic b, input logic f,
                              input logic sc, input int thr);
        bit any_act;
        any_act = r || b || f;
`ifdef CLK_GATE_STAT_EN
        if (sc) m_gc = 0;
        else if (m_mode == 2 && m_gc < 64'h0000_0000_FFFF_FFFF) m_gc = m_gc + 1;
`else
        m_gc = 0;
`endif
        if (m_mode == 0) begin
            if (!any_act) begin m_mode = 1; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (any_act) begin m_mode = 0; m_cnt = 0; end
            else if (m_cnt >= thr) m_mode = 2;
            else m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else if (m_mode == 2) begin
            if (r || f) begin m_mode = 3; m_cnt = 0; end
        end else begin
            if (m_cnt == WAKE_CYC - 1) m_mode = 0;
            else m_cnt = m_cnt + 1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 0; busy = 0; force_on = 0; stat_clr = 0;
        idle_thr = 8'd3;
        repeat (2) tick;
        checks++;
        if (state_o !== 2'd3 || gate_en !== 1'b1 || ack !== 1'b0 || gated_cyc !== 32'd0) begin
            failures++;
            $display("FAIL reset: got state=%0d gate_en=%0b ack=%0b gated_cyc=%0d, expected 3/1/0/0",
                     state_o, gate_en, ack, gated_cyc);
        end
    endtask

    task automatic test_wake_timeline;
        int exp_st;
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick;
            exp_st = (k < 4) ? 3 : (k == 4) ? 0 : (k < 9) ? 1 : 2;
            checks++;
            if (state_o !== 2'(exp_st) || gate_en !== (exp_st != 2) || ack !== (exp_st < 2)) begin
                failures++;
                $display("FAIL wake_timeline cyc=%0d: got state=%0d gate_en=%0b ack=%0b, expected state=%0d",
                         k, state_o, gate_en, ack, exp_st);
            end
        end
    endtask

    task automatic test_off_wake;
        req = 1'b1;
        tick;
        checks++;
        if (state_o !== 2'd3 || gate_en !== 1'b1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL off_to_wake: got state=%0d gate_en=%0b ack=%0b, expected 3/1/0",
                     state_o, gate_en, ack);
        end
        for (int k = 2; k <= 4; k++) begin
            tick;
            checks++;
            if (state_o !== 2'd3 || ack !== 1'b0) begin
                failures++;
                $display("FAIL wake_hold cyc=%0d: got state=%0d ack=%0b, expected 3/0", k, state_o, ack);
            end
        end
        tick;
        checks++;
        if (state_o !== 2'd0 || ack !== 1'b1) begin
            failures++;
            $display("FAIL wake_ack: got state=%0d ack=%0b, expected 0/1", state_o, ack);
        end
        repeat (5) begin
            tick;
            checks++;
            if (ack !== 1'b1 || state_o !== 2'd0) begin
                failures++;
                $display("FAIL ack_held: got state=%0d ack=%0b, expected 0/1", state_o, ack);
            end
        end
    endtask

    task automatic test_threshold_race;
        idle_thr = 8'd3;
        req      = 1'b0;
        tick;
        checks++;
        if (state_o !== 2'd1 || gate_en !== 1'b1) begin
            failures++;
            $display("FAIL enter_count: got state=%0d gate_en=%0b, expected 1/1", state_o, gate_en);
        end
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++;
            if (state_o !== 2'd1 || gate_en !== 1'b1) begin
                failures++;
                $display("FAIL count_hold cyc=%0d: got state=%0d gate_en=%0b, expected 1/1",
                         k, state_o, gate_en);
            end
        end
        busy = 1'b1;
        tick;
        checks++;
        if (state_o !== 2'd0 || gate_en !== 1'b1 || ack !== 1'b1) begin
            failures++;
            $display("FAIL threshold_race: got state=%0d gate_en=%0b ack=%0b, expected 0/1/1",
                     state_o, gate_en, ack);
        end
        busy = 1'b0;
    endtask

    task automatic test_idle_zero_force;
        idle_thr = 8'd0;
        tick;
        checks++;
        if (state_o !== 2'd1) begin
            failures++;
            $display("FAIL thr0_count: got state=%0d, expected 1", state_o);
        end
        tick;
        checks++;
        if (state_o !== 2'd2 || gate_en !== 1'b0) begin
            failures++;
            $display("FAIL thr0_off: got state=%0d gate_en=%0b, expected 2/0", state_o, gate_en);
        end
        force_on = 1'b1;
        tick;
        checks++;
        if (state_o !== 2'd3 || gate_en !== 1'b1) begin
            failures++;
            $display("FAIL force_wake: got state=%0d gate_en=%0b, expected 3/1", state_o, gate_en);
        end
        repeat (4) tick;
        repeat (10) begin
            checks++;
            if (state_o !== 2'd0 || ack !== 1'b1) begin
                failures++;
                $display("FAIL force_hold: got state=%0d ack=%0b, expected 0/1", state_o, ack);
            end
            tick;
        end
        force_on = 1'b0;
    endtask

    task automatic test_reset_mid;
        // Enter WAKE, then reset two cycles into it.
        idle_thr = 8'd0;
        tick;
        tick;
        req = 1'b1;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 2'd3 || gate_en !== 1'b1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wake: got state=%0d gate_en=%0b ack=%0b, expected 3/1/0",
                     state_o, gate_en, ack);
        end
        req = 1'b0;
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        checks++;
        if (state_o !== 2'd3) begin
            failures++;
            $display("FAIL restart_wake_a: got state=%0d, expected 3", state_o);
        end
        tick;
        checks++;
        if (state_o !== 2'd0 || ack !== 1'b1) begin
            failures++;
            $display("FAIL restart_wake_b: got state=%0d ack=%0b, expected 0/1", state_o, ack);
        end
        // Reach OFF, then reset.
        tick;
        tick;
        checks++;
        if (state_o !== 2'd2) begin
            failures++;
            $display("FAIL reach_off: got state=%0d, expected 2", state_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 2'd3 || gate_en !== 1'b1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_off: got state=%0d gate_en=%0b ack=%0b, expected 3/1/0",
                     state_o, gate_en, ack);
        end
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        checks++;
        if (state_o !== 2'd3) begin
            failures++;
            $display("FAIL restart_wake_c: got state=%0d, expected 3", state_o);
        end
        tick;
        checks++;
        if (state_o !== 2'd0 || ack !== 1'b1) begin
            failures++;
            $display("FAIL restart_wake_d: got state=%0d ack=%0b, expected 0/1", state_o, ack);
        end
    endtask

    task automatic test_stats;
        logic [31:0] exp10;
        logic [31:0] exp1;
`ifdef CLK_GATE_STAT_EN
        exp10 = 32'd10;
        exp1  = 32'd1;
`else
        exp10 = 32'd0;
        exp1  = 32'd0;
`endif
        // RUN with idle_thr=0: COUNT then OFF.
        idle_thr = 8'd0;
        tick;
        tick;
        repeat (10) tick;
        checks++;
        if (gated_cyc !== exp10 || state_o !== 2'd2) begin
            failures++;
            $display("FAIL stat_count: got gated_cyc=%0d state=%0d, expected %0d/2",
                     gated_cyc, state_o, exp10);
        end
        stat_clr = 1'b1;
        tick;
        checks++;
        if (gated_cyc !== 32'd0) begin
            failures++;
            $display("FAIL stat_clear: got gated_cyc=%0d, expected 0", gated_cyc);
        end
        stat_clr = 1'b0;
        tick;
        checks++;
        if (gated_cyc !== exp1) begin
            failures++;
            $display("FAIL stat_resume: got gated_cyc=%0d, expected %0d", gated_cyc, exp1);
        end
        req = 1'b1;
        repeat (5) tick;
        req = 1'b0;
    endtask

    task automatic test_random;
        logic exp_gate;
        logic exp_ack;
        rst_n = 1'b0;
        req = 0; busy = 0; force_on = 0; stat_clr = 0;
        idle_thr = 8'd2;
        tick;
        m_mode = 3;
        m_cnt  = 0;
        m_gc   = 0;
        rst_n  = 1'b1;
        for (int i = 0; i < 600; i++) begin
            req      = ($urandom_range(0, 9) < 2);
            busy     = ($urandom_range(0, 9) == 0);
            force_on = ($urandom_range(0, 29) == 0);
            stat_clr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0)
                idle_thr = IDLE_W'($urandom_range(0, 6));
            model_edge(req, busy, force_on, stat_clr, int'(idle_thr));
            tick;
            exp_gate = (m_mode != 2);
            exp_ack  = (m_mode < 2);
            checks++;
            if (state_o !== 2'(m_mode) || gate_en !== exp_gate || ack !== exp_ack ||
                gated_cyc !== 32'(m_gc)) begin
                failures++;
                $display("FAIL random cyc=%0d: got state=%0d gate_en=%0b ack=%0b gated_cyc=%0d, expected %0d/%0b/%0b/%0d",
                         i, state_o, gate_en, ack, gated_cyc, m_mode, exp_gate, exp_ack, m_gc);
            end
        end
        req = 0; busy = 0; force_on = 0; stat_clr = 0;
    endtask

    initial begin
        test_reset;
        test_wake_timeline;
        test_off_wake;
        test_threshold_race;
        test_idle_zero_force;
        test_reset_mid;
        test_stats;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter IDLE_W, default 8: width of the idle-threshold input and of the idle counter.
REQ-002 Parameter WAKE_CYC, default 4: cycles from clock re-enable until ack; legal range 1..255.
REQ-003 clk  input  1  free-running ungated clock; all block state on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  1  client requests gated clock.
REQ-006 busy  input  1  gated-domain activity flag; sampled only while the gated clock runs.
REQ-007 force_on  input  1  keeps clock enabled regardless of idle state.
REQ-008 idle_thr  input  IDLE_W  idle cycles tolerated before gating.
REQ-009 stat_clr  input  1  synchronous clear of the gated-cycle counter.
REQ-010 gate_en  output  1  registered enable to the downstream icg E pin.
REQ-011 ack  output  1  gated clock stable and usable.
REQ-012 state_o  output  2  current state: RUN=0, COUNT=1, OFF=2, WAKE=3.
REQ-013 gated_cyc  output  32  count of cycles spent in OFF.

Function
REQ-014 The FSM SHALL have states RUN, COUNT, OFF and WAKE, held in one register; gate_en, ack and state_o decode directly from registers, with no combinational path from any input.
REQ-015 gate_en SHALL be 1 in RUN, COUNT and WAKE, and 0 only in OFF.
REQ-016 ack SHALL be 1 in RUN and COUNT, and 0 in OFF and WAKE.
REQ-017 RUN -> COUNT, with the counter cleared to 0, when req=0, busy=0 and force_on=0.
REQ-018 COUNT -> RUN when any of req, busy or force_on is 1; the counter is cleared and no wake delay applies.
REQ-019 COUNT: the counter increments each cycle; COUNT -> OFF when counter >= idle_thr.
REQ-020 With idle_thr=0, the FSM SHALL enter OFF on the cycle after entering COUNT.
REQ-021 idle_thr SHALL be compared live, so a change mid-COUNT takes effect on the next comparison.
REQ-022 COUNT: if req/busy/force_on rise in the same cycle the threshold is reached, RUN SHALL win.
REQ-023 OFF: busy SHALL be ignored; OFF -> WAKE, with the counter cleared, when req=1 or force_on=1.
REQ-024 WAKE: the counter increments; WAKE -> RUN when counter == WAKE_CYC-1, so ack rises exactly WAKE_CYC cycles after entering WAKE.
REQ-025 WAKE SHALL NOT be abortable; a req drop during WAKE still completes to RUN, then follows REQ-017.
REQ-026 Counter width SHALL be max(IDLE_W, 8) bits and SHALL never wrap in COUNT; it saturates.
REQ-027 Handshake: a client SHALL hold req until ack=1; ack stays 1 while req=1.

Reset
REQ-028 On rst_n=0, asynchronously: state=WAKE, counter=0, gate_en=1, ack=0, state_o=3, gated_cyc=0.
REQ-029 After reset release, the block SHALL complete WAKE and enter RUN after WAKE_CYC cycles.
REQ-030 Reset asserted mid-operation in any state SHALL return to the REQ-028 values immediately.

Configuration
REQ-031 Macro CLK_GATE_STAT_EN defined: gated_cyc increments once per cycle in OFF, saturates at 32'hFFFF_FFFF and clears on stat_clr=1; clear takes priority over increment.
REQ-032 Macro CLK_GATE_STAT_EN undefined: ports are retained, gated_cyc is constant 0, stat_clr is ignored, and no counter flops exist.

Verification
REQ-033 Reset release, req=0, busy=0, idle_thr=3, WAKE_CYC=4 -> ack=1 at cycle 4, COUNT at cycle 5, OFF and gate_en=0 at cycle 9.
REQ-034 In OFF, assert req -> WAKE next cycle, gate_en=1 immediately, ack=1 exactly 4 cycles later; hold req and verify ack stays 1.
REQ-035 In COUNT at counter==idle_thr-1, pulse busy on the threshold cycle -> RUN, gate_en never drops.
REQ-036 idle_thr=0 -> RUN, COUNT, OFF on consecutive cycles; force_on=1 in OFF -> WAKE; force_on held -> never leaves RUN.
REQ-037 Assert rst_n=0 mid-WAKE and mid-OFF -> same-cycle state_o=3, gate_en=1, ack=0, and the WAKE count restarts.
REQ-038 CLK_GATE_STAT_EN defined: 10 cycles in OFF -> gated_cyc=10; stat_clr concurrent with OFF -> 0; preload near max -> saturates. Undefined -> gated_cyc always 0.
